// File: rtl/adpll_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adpll_cfg_pkg
// Brief    : Shared widths, default loop constants and sequencer state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package adpll_cfg_pkg;

    localparam int PARAM_W        = 5;
    localparam int SEL_W          = 3;

    localparam int NPARAM_DEF     = 8;
    localparam int PGM_HOLD_DEF   = 4;
    localparam int CLR_CYC_DEF    = 16;
    localparam int LOCK_THR_DEF   = 2;
    localparam int LOCK_CNT_DEF   = 64;
    localparam int UNLOCK_CNT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_GAP     = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_MONITOR = 3'd5
    } state_t;

    // Bits needed to hold every value in 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adpll_lock_det.sv
`default_nettype none
// ============================================================================
// Module   : adpll_lock_det
// Brief    : Phase-error window counters producing locked and sticky lost_lock.
// Revision : 1.0 - initial release
// ============================================================================
module adpll_lock_det
    import adpll_cfg_pkg::*;
#(
    parameter int LOCK_THR   = LOCK_THR_DEF,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               load,
    input  logic [PARAM_W-1:0] dout,
    output logic               locked,
    output logic               lost_lock
);

    localparam int IN_W  = cnt_width(LOCK_CNT);
    localparam int OUT_W = cnt_width(UNLOCK_CNT);

    logic [IN_W-1:0]  r_in_cnt;
    logic [OUT_W-1:0] r_out_cnt;
    logic             r_locked;
    logic             r_lost;
    logic             w_in_win;

    assign w_in_win  = (dout <= PARAM_W'(LOCK_THR));
    assign locked    = r_locked;
    assign lost_lock = r_lost;

    // Lock asserts on the same edge that in_cnt reaches LOCK_CNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_locked  <= 1'b0;
            r_lost    <= 1'b0;
        end else if (load) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_locked  <= 1'b0;
            r_lost    <= 1'b0;
        end else if (!en) begin
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_locked  <= 1'b0;
        end else if (w_in_win) begin
            r_out_cnt <= '0;
            if (r_in_cnt != IN_W'(LOCK_CNT))
                r_in_cnt <= r_in_cnt + 1'b1;
            if (r_in_cnt == IN_W'(LOCK_CNT - 1))
                r_locked <= 1'b1;
        end else begin
            r_in_cnt <= '0;
            if (r_locked) begin
                if (r_out_cnt == OUT_W'(UNLOCK_CNT - 1)) begin
                    r_locked  <= 1'b0;
                    r_lost    <= 1'b1;
                    r_out_cnt <= '0;
                end else begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adpll_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : adpll_cfg_seq
// Brief    : Shadow parameter table, program-strobe sequencer and lock monitor.
// Revision : 1.0 - initial release
// ============================================================================
module adpll_cfg_seq
    import adpll_cfg_pkg::*;
#(
    parameter int NPARAM     = NPARAM_DEF,
    parameter int PGM_HOLD   = PGM_HOLD_DEF,
    parameter int CLR_CYC    = CLR_CYC_DEF,
    parameter int LOCK_THR   = LOCK_THR_DEF,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               wr_en,
    input  logic [SEL_W-1:0]   wr_addr,
    input  logic [PARAM_W-1:0] wr_data,
    input  logic [PARAM_W-1:0] dout,
    input  logic               sign,
    output logic               pgm,
    output logic [SEL_W-1:0]   param_sel,
    output logic [PARAM_W-1:0] pgm_value,
    output logic               clr,
    output logic               busy,
    output logic               done,
    output logic               locked,
    output logic               lost_lock
);

    localparam int HOLD_MAX = (PGM_HOLD > CLR_CYC) ? PGM_HOLD : CLR_CYC;
    localparam int HOLD_W   = cnt_width(HOLD_MAX);

    state_t             r_state;
    state_t             w_state_next;
    logic [SEL_W-1:0]   r_idx;
    logic [HOLD_W-1:0]  r_hold;
    logic [PARAM_W-1:0] r_table [NPARAM];
    logic               r_done;
    logic               w_load;
    logic               w_mon_en;
    logic               w_unused_sign;

    // Phase-error sign is only of interest to external trace.
    assign w_unused_sign = sign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        pgm          = 1'b0;
        clr          = 1'b0;
        busy         = 1'b0;
        param_sel    = '0;
        pgm_value    = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SETUP;
                    w_load       = 1'b1;
                end
            end
            ST_SETUP: begin
                busy         = 1'b1;
                param_sel    = r_idx;
                pgm_value    = r_table[r_idx];
                w_state_next = ST_STROBE;
            end
            ST_STROBE: begin
                busy      = 1'b1;
                pgm       = 1'b1;
                param_sel = r_idx;
                pgm_value = r_table[r_idx];
                if (r_hold == HOLD_W'(PGM_HOLD - 1))
                    w_state_next = ST_GAP;
            end
            ST_GAP: begin
                busy      = 1'b1;
                param_sel = r_idx;
                pgm_value = r_table[r_idx];
                if (r_idx == SEL_W'(NPARAM - 1)) w_state_next = ST_CLEAR;
                else                             w_state_next = ST_SETUP;
            end
            ST_CLEAR: begin
                busy = 1'b1;
                clr  = 1'b1;
                if (r_hold == HOLD_W'(CLR_CYC - 1))
                    w_state_next = ST_MONITOR;
            end
            ST_MONITOR: begin
                if (start) begin
                    w_state_next = ST_SETUP;
                    w_load       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (abort) begin
            w_state_next = ST_IDLE;
            w_load       = 1'b0;
        end
    end

    // One hold counter serves both STROBE and CLEAR; it restarts on every state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_hold <= '0;
        else if (w_state_next != r_state)
            r_hold <= '0;
        else if (r_state == ST_STROBE || r_state == ST_CLEAR)
            r_hold <= r_hold + 1'b1;
        else
            r_hold <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_idx <= '0;
        else if (w_load)
            r_idx <= '0;
        else if (r_state == ST_GAP && w_state_next == ST_SETUP)
            r_idx <= r_idx + 1'b1;
    end

    // Writes land in IDLE/MONITOR only, so a write coincident with start is seen by SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPARAM; i++)
                r_table[i] <= '0;
        end else if (wr_en && !busy) begin
            for (int i = 0; i < NPARAM; i++)
                if (wr_addr == SEL_W'(i))
                    r_table[i] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= (r_state == ST_CLEAR) && (w_state_next == ST_MONITOR);
    end

    assign done     = r_done;
    assign w_mon_en = (r_state == ST_MONITOR) && (w_state_next == ST_MONITOR);

    adpll_lock_det #(
        .LOCK_THR   (LOCK_THR),
        .LOCK_CNT   (LOCK_CNT),
        .UNLOCK_CNT (UNLOCK_CNT)
    ) u_lock_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (w_mon_en),
        .load      (w_load),
        .dout      (dout),
        .locked    (locked),
        .lost_lock (lost_lock)
    );

endmodule
`default_nettype wire

// File: tb/tb_adpll_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_adpll_cfg_seq
// Brief    : Randomized self-checking bench for the ADPLL configuration sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adpll_cfg_seq;

    localparam int NP    = 8;
    localparam int SLOT  = 6;                 // SETUP + 4 STROBE + GAP
    localparam int CLR_S = NP * SLOT;         // first CLEAR offset
    localparam int DONE_O = NP * SLOT + 16;   // first MONITOR offset

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [4:0] dout = '0;
    logic       sign = 1'b0;
    logic       pgm, clr, busy, done, locked, lost_lock;
    logic [2:0] param_sel;
    logic [4:0] pgm_value;
    logic [13:0] act;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0] model_tbl [NP];
    bit         exp_locked;
    bit         exp_lost;
    int         run_in;
    int         run_out;

    adpll_cfg_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .dout      (dout),
        .sign      (sign),
        .pgm       (pgm),
        .param_sel (param_sel),
        .pgm_value (pgm_value),
        .clr       (clr),
        .busy      (busy),
        .done      (done),
        .locked    (locked),
        .lost_lock (lost_lock)
    );

    always #5 clk = ~clk;

    assign act = {pgm, param_sel, pgm_value, clr, busy, done, locked, lost_lock};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // Expected outputs o cycles after the first SETUP cycle of a load.
    function automatic logic [13:0] exp_load(input int o);
        logic       p, c, b, d;
        logic [2:0] s;
        logic [4:0] v;
        p = 1'b0; c = 1'b0; b = 1'b0; d = 1'b0; s = '0; v = '0;
        if (o < CLR_S) begin
            b = 1'b1;
            s = 3'(o / SLOT);
            v = model_tbl[o / SLOT];
            p = ((o % SLOT) >= 1) && ((o % SLOT) <= 4);
        end else if (o < DONE_O) begin
            b = 1'b1;
            c = 1'b1;
        end else begin
            d = 1'b1;
        end
        return {p, s, v, c, b, d, 1'b0, 1'b0};
    endfunction

    // Lock rules: 64 consecutive in-window cycles lock; 8 consecutive misses while locked lose it.
    task automatic model_step(input logic [4:0] dv);
        if (dv <= 5'd2) begin
            run_in++;
            run_out = 0;
            if (run_in >= 64) exp_locked = 1'b1;
        end else begin
            run_in = 0;
            if (exp_locked) begin
                run_out++;
                if (run_out == 8) begin
                    exp_locked = 1'b0;
                    exp_lost   = 1'b1;
                    run_out    = 0;
                end
            end
        end
    endtask

    task automatic write_slot(input logic [2:0] a, input logic [4:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        model_tbl[a] = d;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NP; i++)
            write_slot(3'(i), 5'($urandom_range(0, 31)));
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (act !== {13'b0, exp_lost}) begin
            n_fail++;
            $display("FAIL %s: outputs got %h required %h", tag, act, {13'b0, exp_lost});
        end
    endtask

    // Issues start now (caller is just past a negedge) and checks every cycle through done.
    task automatic run_load(input bit inject, input int abort_at, input int rst_at, input string tag);
        logic [13:0] e;
        start = 1'b1;
        exp_locked = 1'b0; exp_lost = 1'b0; run_in = 0; run_out = 0;
        for (int o = 0; o <= DONE_O; o++) begin
            @(negedge clk);
            start = 1'b0; wr_en = 1'b0; abort = 1'b0;
            e = exp_load(o);
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL load_%s o=%0d: outputs got %h required %h", tag, o, act, e);
            end
            if (inject && (o == 2 || o == 30 || o == 60)) start = 1'b1;
            if (inject && o == 5) begin
                wr_en = 1'b1; wr_addr = 3'd7; wr_data = ~model_tbl[7];
            end
            if (inject && o == 50) begin
                wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = ~model_tbl[wr_addr];
            end
            if (o == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check_idle({"abort_", tag});
                @(negedge clk);
                check_idle({"abort_hold_", tag});
                return;
            end
            if (o == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                for (int i = 0; i < NP; i++) model_tbl[i] = '0;
                exp_lost = 1'b0;
                check_idle({"async_rst_", tag});
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_idle({"post_rst_", tag});
                return;
            end
        end
    endtask

    task automatic run_monitor(input int n, input int mode, input string tag);
        logic [4:0] dv;
        bit         is_out;
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       is_out = 1'b0;
                1:       is_out = (i == 40);
                2:       is_out = (i < 7);
                3:       is_out = (i < 8);
                default: is_out = ($urandom_range(0, 3) == 0);
            endcase
            if (is_out) dv = ($urandom_range(0, 1) == 0) ? 5'd3 : 5'($urandom_range(3, 31));
            else        dv = 5'($urandom_range(0, 2));
            dout = dv;
            sign = 1'($urandom_range(0, 1));
            @(negedge clk);
            model_step(dv);
            n_checks++;
            if ({busy, done, locked, lost_lock} !== {2'b00, exp_locked, exp_lost}) begin
                n_fail++;
                $display("FAIL mon_%s i=%0d: busy/done/locked/lost got %b required %b",
                         tag, i, {busy, done, locked, lost_lock}, {2'b00, exp_locked, exp_lost});
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_lost = 1'b0;
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_load();
        for (int i = 0; i < NP - 1; i++)
            write_slot(3'(i), 5'(2 * i + 1));
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 5'd15;
        model_tbl[7] = 5'd15;
        run_load(1'b0, -1, -1, "odd");
    endtask

    task automatic test_lock();
        run_monitor(70, 0, "lock");
        fill_random();
        run_load(1'b0, -1, -1, "rand1");
        run_monitor(110, 1, "restart");
    endtask

    task automatic test_unlock();
        run_monitor(20, 2, "miss7");
        run_monitor(20, 3, "miss8");
    endtask

    task automatic test_back_to_back();
        fill_random();
        run_load(1'b1, -1, -1, "inject");
        run_monitor(70, 0, "relock");
        run_monitor(12, 3, "drop");
        run_monitor(70, 0, "relock2");
    endtask

    task automatic test_abort();
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        exp_locked = 1'b0;
        check_idle("abort_start_mon");
        @(negedge clk);
        check_idle("abort_start_hold");
        run_load(1'b0, 55, -1, "clear");
    endtask

    task automatic test_reset_mid();
        write_slot(3'd2, 5'($urandom_range(0, 31)));
        run_load(1'b0, -1, 3, "rst");
        write_slot(3'd4, 5'($urandom_range(0, 31)));
        run_load(1'b0, -1, -1, "after_rst");
        run_monitor(60, 4, "random");
    endtask

    initial begin
        for (int i = 0; i < NP; i++) model_tbl[i] = '0;
        exp_locked = 1'b0; exp_lost = 1'b0; run_in = 0; run_out = 0;
        test_reset();
        test_load();
        test_lock();
        test_unlock();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
